// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter: round-robin grant held for the whole CYC,
// responses routed to the owner only, and a bus-error timeout for silent slaves.
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK_I,
    input  logic          RST_NI,
    input  logic          m0_CYC_I,
    input  logic          m0_STB_I,
    input  logic          m0_WE_I,
    input  logic [AW-1:0] m0_ADR_I,
    input  logic [DW-1:0] m0_DAT_I,
    output logic          m0_ACK_O,
    output logic          m0_ERR_O,
    output logic [DW-1:0] m0_DAT_O,
    input  logic          m1_CYC_I,
    input  logic          m1_STB_I,
    input  logic          m1_WE_I,
    input  logic [AW-1:0] m1_ADR_I,
    input  logic [DW-1:0] m1_DAT_I,
    output logic          m1_ACK_O,
    output logic          m1_ERR_O,
    output logic [DW-1:0] m1_DAT_O,
    output logic          s_CYC_O,
    output logic          s_STB_O,
    output logic          s_WE_O,
    output logic [AW-1:0] s_ADR_O,
    output logic [DW-1:0] s_DAT_O,
    input  logic          s_ACK_I,
    input  logic          s_ERR_I,
    input  logic [DW-1:0] s_DAT_I,
    output logic [1:0]    gnt_o
);
    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t        r_state, w_next;
    logic          r_last;   // 1: m1 was granted last
    logic [CW-1:0] r_cnt;
    logic          r_tmo;
    logic          w_stall, w_term;

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == GNT0) r_last <= 1'b0;
            else if (r_state == IDLE && w_next == GNT1) r_last <= 1'b1;
        end
    end

    // Returning to IDLE forces one dead cycle before the next owner is picked.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (m0_CYC_I && (!m1_CYC_I || r_last)) w_next = GNT0;
                else if (m1_CYC_I && (!m0_CYC_I || !r_last)) w_next = GNT1;
            end
            GNT0:    if (!m0_CYC_I) w_next = IDLE;
            GNT1:    if (!m1_CYC_I) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_o    = 2'b00;
        s_CYC_O  = 1'b0;
        s_STB_O  = 1'b0;
        s_WE_O   = 1'b0;
        s_ADR_O  = '0;
        s_DAT_O  = '0;
        m0_ACK_O = 1'b0;
        m0_ERR_O = 1'b0;
        m0_DAT_O = '0;
        m1_ACK_O = 1'b0;
        m1_ERR_O = 1'b0;
        m1_DAT_O = '0;
        unique case (r_state)
            GNT0: begin
                gnt_o    = 2'b01;
                s_CYC_O  = m0_CYC_I;
                s_STB_O  = m0_STB_I & ~r_tmo;
                s_WE_O   = m0_WE_I;
                s_ADR_O  = m0_ADR_I;
                s_DAT_O  = m0_DAT_I;
                m0_ACK_O = s_ACK_I & ~r_tmo;
                m0_ERR_O = s_ERR_I | r_tmo;
                m0_DAT_O = s_DAT_I;
            end
            GNT1: begin
                gnt_o    = 2'b10;
                s_CYC_O  = m1_CYC_I;
                s_STB_O  = m1_STB_I & ~r_tmo;
                s_WE_O   = m1_WE_I;
                s_ADR_O  = m1_ADR_I;
                s_DAT_O  = m1_DAT_I;
                m1_ACK_O = s_ACK_I & ~r_tmo;
                m1_ERR_O = s_ERR_I | r_tmo;
                m1_DAT_O = s_DAT_I;
            end
            default: ;
        endcase
    end

    // A response in the terminal cycle wins over the timeout.
    assign w_stall = s_STB_O & ~s_ACK_I & ~s_ERR_I;
    assign w_term  = w_stall && (r_cnt == TERM);

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_term;
            if (w_term || !w_stall || w_next == IDLE) r_cnt <= '0;
            else r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: scripted scenarios plus random traffic,
// every cycle compared against a behavioural ownership/timeout model.
module tb_wb_arbiter_2m;
    localparam int AW = 32, DW = 32, TMO = 8;

    logic CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    logic          rst_n;
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wdat [2];
    logic          s_ack, s_err;
    logic [DW-1:0] s_dat;

    wire           m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
    wire [DW-1:0]  m0_dat, m1_dat, s_wdat;
    wire [AW-1:0]  s_adr;
    wire [1:0]     gnt;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .CLK_I(CLK_I), .RST_NI(rst_n),
        .m0_CYC_I(cyc[0]), .m0_STB_I(stb[0]), .m0_WE_I(we[0]), .m0_ADR_I(adr[0]), .m0_DAT_I(wdat[0]),
        .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err), .m0_DAT_O(m0_dat),
        .m1_CYC_I(cyc[1]), .m1_STB_I(stb[1]), .m1_WE_I(we[1]), .m1_ADR_I(adr[1]), .m1_DAT_I(wdat[1]),
        .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err), .m1_DAT_O(m1_dat),
        .s_CYC_O(s_cyc), .s_STB_O(s_stb), .s_WE_O(s_we), .s_ADR_O(s_adr), .s_DAT_O(s_wdat),
        .s_ACK_I(s_ack), .s_ERR_I(s_err), .s_DAT_I(s_dat), .gnt_o(gnt)
    );

    wire  [136:0] obs_v = {gnt, s_cyc, s_stb, s_we, s_adr, s_wdat,
                           m0_ack, m0_err, m0_dat, m1_ack, m1_err, m1_dat};
    logic [136:0] exp_v;
    logic [1:0]   e_ack, e_err;
    int checks = 0, errors = 0;

    // Model: who owns the bus (-1 none), who owned it last, stall count, timeout flag.
    int m_own = -1, m_last = 1, m_cnt = 0;
    bit m_tmo = 0;

    task automatic model_eval();
        logic [1:0]    g;
        logic          sc, ss, sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd, md0, md1;
        g = '0; sc = 0; ss = 0; sw = 0; sa = '0; sd = '0; md0 = '0; md1 = '0;
        e_ack = '0; e_err = '0;
        if (m_own >= 0) begin
            g[m_own] = 1'b1;
            sc = cyc[m_own]; ss = stb[m_own] && !m_tmo; sw = we[m_own];
            sa = adr[m_own]; sd = wdat[m_own];
            e_ack[m_own] = s_ack && !m_tmo;
            e_err[m_own] = s_err || m_tmo;
            if (m_own == 0) md0 = s_dat; else md1 = s_dat;
        end
        exp_v = {g, sc, ss, sw, sa, sd, e_ack[0], e_err[0], md0, e_ack[1], e_err[1], md1};
    endtask

    task automatic model_clk();
        int nxt;
        bit stall, term;
        if (!rst_n) begin
            m_own = -1; m_last = 1; m_cnt = 0; m_tmo = 0;
        end else begin
            nxt = m_own;
            if (m_own < 0) begin
                if (cyc[0] && (!cyc[1] || m_last == 1)) nxt = 0;
                else if (cyc[1] && (!cyc[0] || m_last == 0)) nxt = 1;
                if (nxt >= 0) m_last = nxt;
            end else if (!cyc[m_own]) nxt = -1;
            stall = (m_own >= 0) && stb[m_own] && !m_tmo && !s_ack && !s_err;
            term  = stall && (m_cnt == TMO - 1);
            m_cnt = (term || !stall || nxt < 0) ? 0 : m_cnt + 1;
            m_tmo = term;
            m_own = nxt;
        end
    endtask

    task automatic settle();
        @(negedge CLK_I);
        model_eval();
    endtask

    task automatic adv();
        @(posedge CLK_I);
        model_clk();
        #1;
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0; s_ack = 0; s_err = 0; s_dat = '0;
        for (int i = 0; i < 2; i++) begin adr[i] = '0; wdat[i] = '0; end
    endtask

    task automatic do_reset();
        rst_n = 0; clear_inputs(); adv(); adv(); rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; cyc = 2'b11; stb = 2'b11; s_ack = 1; s_err = 1; s_dat = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            adv(); settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset k=%0d got=%h want=%h", k, obs_v, exp_v); end
            checks++;
            if (obs_v !== '0) begin errors++; $display("FAIL reset_zero k=%0d got=%h want=0", k, obs_v); end
        end
        rst_n = 1; clear_inputs(); adv();
    endtask

    task automatic test_single_write();
        int n0 = 0, n1 = 0;
        for (int k = 0; k <= 4; k++) begin
            cyc[0] = (k < 4); stb[0] = (k < 4); we[0] = 1; adr[0] = 32'h4; wdat[0] = 32'hA5A5_A5A5;
            s_ack = (k == 3);
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL single_write k=%0d got=%h want=%h", k, obs_v, exp_v); end
            if (k == 1) begin
                checks++;
                if ({gnt, s_adr, s_wdat, s_we} !== {2'b01, 32'h4, 32'hA5A5_A5A5, 1'b1}) begin
                    errors++; $display("FAIL single_write_mirror got=%b/%h/%h want=01/4/a5a5a5a5", gnt, s_adr, s_wdat);
                end
            end
            n0 += int'(m0_ack); n1 += int'(m1_ack);
            adv();
        end
        checks++;
        if (n0 != 1 || n1 != 0) begin errors++; $display("FAIL single_write_acks got=%0d/%0d want=1/0", n0, n1); end
    endtask

    task automatic test_tie_rr();
        logic [1:0] order [3];
        do_reset();
        for (int r = 0; r < 3; r++) begin
            cyc = 2'b11; stb = 2'b11; s_ack = 0;
            settle();
            checks++;
            if (obs_v !== exp_v || gnt !== 2'b00) begin errors++; $display("FAIL tie_idle r=%0d got=%h want=%h", r, obs_v, exp_v); end
            adv();
            s_ack = 1;
            settle();
            order[r] = gnt;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL tie_beat r=%0d got=%h want=%h", r, obs_v, exp_v); end
            adv();
            cyc = 2'b00; stb = 2'b00; s_ack = 0;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL tie_drop r=%0d got=%h want=%h", r, obs_v, exp_v); end
            adv();
        end
        checks++;
        if ({order[0], order[1], order[2]} !== 6'b01_10_01) begin
            errors++; $display("FAIL tie_order got=%b%b%b want=011001", order[0], order[1], order[2]);
        end
    endtask

    task automatic test_hold_grant();
        for (int k = 0; k <= 12; k++) begin
            cyc[0] = (k < 9); stb[0] = (k < 9); we[0] = 0;
            cyc[1] = (k >= 1 && k < 12); stb[1] = cyc[1];
            s_dat = 32'h1234_5678;
            s_ack = (k >= 2 && k <= 8 && k % 2 == 0) || k == 11;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL hold k=%0d got=%h want=%h", k, obs_v, exp_v); end
            if (k >= 1 && k <= 8) begin
                checks++;
                if (m0_dat !== 32'h1234_5678 || m1_dat !== '0 || m1_ack !== 1'b0) begin
                    errors++; $display("FAIL hold_route k=%0d got=%h/%h want=12345678/0", k, m0_dat, m1_dat);
                end
            end
            if (k >= 9 && k <= 11) begin
                checks++;
                if (gnt !== (k == 9 ? 2'b01 : k == 10 ? 2'b00 : 2'b10)) begin
                    errors++; $display("FAIL hold_handover k=%0d got=%b", k, gnt);
                end
            end
            adv();
        end
    endtask

    task automatic test_timeout();
        clear_inputs();
        for (int k = 0; k <= 20; k++) begin
            cyc[1] = (k < 20); stb[1] = (k < 20); adr[1] = 32'h40;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL timeout k=%0d got=%h want=%h", k, obs_v, exp_v); end
            if (k >= 1 && k < 20) begin
                checks++;
                if (m1_err !== (k == 9 || k == 18) || s_stb !== !(k == 9 || k == 18) || m0_err !== 1'b0) begin
                    errors++; $display("FAIL timeout_err k=%0d got=%b/%b", k, m1_err, s_stb);
                end
            end
            adv();
        end
    endtask

    task automatic test_ack_at_terminal();
        clear_inputs();
        for (int k = 0; k <= 13; k++) begin
            cyc[0] = (k < 11); stb[0] = (k < 11);
            cyc[1] = (k >= 9 && k < 13); stb[1] = cyc[1];
            s_ack = (k == 8); s_err = (k == 10);
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ack_term k=%0d got=%h want=%h", k, obs_v, exp_v); end
            if (k == 8 || k == 9 || k == 10) begin
                checks++;
                if ({m0_ack, m0_err, m1_err} !== {k == 8, k == 10, 1'b0}) begin
                    errors++; $display("FAIL ack_term_resp k=%0d got=%b%b%b", k, m0_ack, m0_err, m1_err);
                end
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        for (int k = 0; k <= 6; k++) begin
            rst_n = !(k == 2 || k == 3);
            cyc[1] = (k < 4) || k == 5; stb[1] = cyc[1];
            cyc[0] = (k == 5); stb[0] = cyc[0];
            s_ack = (k == 3); s_dat = 32'hCAFE_0001;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset_mid k=%0d got=%h want=%h", k, obs_v, exp_v); end
            if (k == 1 || k == 3 || k == 6) begin
                checks++;
                if (gnt !== (k == 1 ? 2'b10 : k == 3 ? 2'b00 : 2'b01) || (k == 3 && obs_v !== '0)) begin
                    errors++; $display("FAIL reset_mid_gnt k=%0d got=%b", k, gnt);
                end
            end
            adv();
        end
        clear_inputs(); adv();
    endtask

    task automatic test_random();
        int mb [2];
        mb[0] = 0; mb[1] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (mb[i] == 0 && $urandom_range(0, 3) == 0) mb[i] = $urandom_range(1, 3);
                cyc[i] = (mb[i] > 0); stb[i] = cyc[i]; we[i] = 1'($urandom);
                adr[i] = $urandom; wdat[i] = $urandom;
            end
            s_ack = ($urandom_range(0, 2) == 0); s_err = ($urandom_range(0, 15) == 0); s_dat = $urandom;
            rst_n = ($urandom_range(0, 149) != 0);
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random k=%0d got=%h want=%h", k, obs_v, exp_v); end
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) mb[i] = 0;
                else if ((e_ack[i] || e_err[i]) && mb[i] > 0) mb[i]--;
            end
            adv();
        end
        rst_n = 1; clear_inputs(); adv();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_tie_rr();
        test_hold_grant();
        test_timeout();
        test_ack_at_terminal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
